fastica_one_unit: RTL and testbench

//  One fixed-point FastICA update (kurtosis nonlinearity g(y)=y^3) for a 4-channel whitened stream.
//  - Latches a 4x4 demixing matrix W on start and streams NSAMP whitened samples z.
//  - Returns W+ = E{z*(W z)^3} - 3W; row decorrelation/normalisation is done downstream.

---
 rtl/fastica_pkg.sv | 41 ++++
 rtl/fastica_row.sv | 64 ++++++
 rtl/fastica_one_unit.sv | 163 ++++++++++++++++
 tb/tb_fastica_one_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fastica_pkg.sv
// Shared types, constants and fixed-point helpers for the FastICA one-unit update.
package fastica_pkg;

  localparam int DW        = 26;
  localparam int FRAC_BITS = 13;

  typedef logic signed [DW-1:0]   data_t;
  typedef logic signed [2*DW-1:0] prod_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_UPDATE
  } state_t;

  localparam logic signed [63:0] SAT_HI = (64'sd1 <<< (DW - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_LO = -(64'sd1 <<< (DW - 1));

  // Clamp a wide signed value into the DW-bit signed range.
  function automatic data_t sat(input logic signed [63:0] x);
    if (x > SAT_HI) begin
      sat = data_t'(SAT_HI);
    end else if (x < SAT_LO) begin
      sat = data_t'(SAT_LO);
    end else begin
      sat = data_t'(x);
    end
  endfunction

  // Full-precision signed product.
  function automatic prod_t mul_full(input data_t a, input data_t b);
    mul_full = prod_t'(a) * prod_t'(b);
  endfunction

  // Fixed-point multiply: full product, arithmetic shift, saturate.
  function automatic data_t mul_shift(input data_t a, input data_t b);
    mul_shift = sat(64'(mul_full(a, b) >>> FRAC_BITS));
  endfunction

endpackage

// File: rtl/fastica_row.sv
// One demixing row: dot product, cube nonlinearity and four column accumulators.
module fastica_row
  import fastica_pkg::*;
#(
  parameter int ACC_W = 56
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    acc_en,
  input  data_t                   w_row [4],
  input  data_t                   z_s0  [4],
  input  data_t                   z_s3  [4],
  output logic signed [ACC_W-1:0] acc   [4]
);

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [2*DW+1:0]  dot_t;

  data_t y_q, y_d, yd_q, yd_d, y2_q, y2_d, g_q, g_d;
  acc_t  acc_q [4];
  acc_t  acc_d [4];
  dot_t  dot;

  // Pipeline stages S1..S4 for this row.
  always_comb begin
    dot = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      dot = dot + dot_t'(mul_full(w_row[j], z_s0[j]));
    end
    y_d  = sat(64'(dot >>> FRAC_BITS));
    y2_d = mul_shift(y_q, y_q);
    yd_d = y_q;
    g_d  = mul_shift(y2_q, yd_q);
    for (int unsigned j = 0; j < 4; j++) begin
      acc_d[j] = acc_q[j];
      if (clr) begin
        acc_d[j] = '0;
      end else if (acc_en) begin
        acc_d[j] = acc_q[j] + acc_t'(mul_full(z_s3[j], g_q) >>> FRAC_BITS);
      end
    end
  end

  // Stage registers and accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      yd_q  <= '0;
      y2_q  <= '0;
      g_q   <= '0;
      acc_q <= '{default: '0};
    end else begin
      y_q   <= y_d;
      yd_q  <= yd_d;
      y2_q  <= y2_d;
      g_q   <= g_d;
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fastica_one_unit.sv
// FastICA one-unit update: W+ = E{z*(Wz)^3} - 3W over 2**LOG2_NSAMP samples.
module fastica_one_unit
  import fastica_pkg::*;
#(
  parameter int LOG2_NSAMP = 8,
  parameter int ACC_W      = 56
) (
  input  logic              clk_fast,
  input  logic              rstn_fast,
  input  logic              go_fast,
  input  logic signed [DW-1:0] z1, z2, z3, z4,
  input  logic signed [DW-1:0] w11_in, w12_in, w13_in, w14_in,
  input  logic signed [DW-1:0] w21_in, w22_in, w23_in, w24_in,
  input  logic signed [DW-1:0] w31_in, w32_in, w33_in, w34_in,
  input  logic signed [DW-1:0] w41_in, w42_in, w43_in, w44_in,
  output logic              fast_busy,
  output logic signed [DW-1:0] w11_out, w12_out, w13_out, w14_out,
  output logic signed [DW-1:0] w21_out, w22_out, w23_out, w24_out,
  output logic signed [DW-1:0] w31_out, w32_out, w33_out, w34_out,
  output logic signed [DW-1:0] w41_out, w42_out, w43_out, w44_out
);

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [DW+1:0]    w3_t;
  typedef logic signed [DW+2:0]    diff_t;

  localparam logic [LOG2_NSAMP:0] RUN_LAST   = (LOG2_NSAMP+1)'((1 << LOG2_NSAMP) - 1);
  localparam logic [LOG2_NSAMP:0] DRAIN_LAST = (LOG2_NSAMP+1)'(2);

  state_t              state_q, state_d;
  logic [LOG2_NSAMP:0] cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic                clr;
  data_t               w_in_m [4][4];
  data_t               w_q    [4][4];
  data_t               w_d    [4][4];
  data_t               wout_q [4][4];
  data_t               wout_d [4][4];
  data_t               z_in   [4];
  data_t               z1_q [4], z1_d [4], z2_q [4], z2_d [4], z3_q [4], z3_d [4];
  acc_t                acc_m  [4][4];
  data_t               mean;
  w3_t                 w3;
  diff_t               diff;

  assign z_in = '{z1, z2, z3, z4};
  assign w_in_m[0] = '{w11_in, w12_in, w13_in, w14_in};
  assign w_in_m[1] = '{w21_in, w22_in, w23_in, w24_in};
  assign w_in_m[2] = '{w31_in, w32_in, w33_in, w34_in};
  assign w_in_m[3] = '{w41_in, w42_in, w43_in, w44_in};

  assign fast_busy = busy_q;
  assign w11_out = wout_q[0][0]; assign w12_out = wout_q[0][1];
  assign w13_out = wout_q[0][2]; assign w14_out = wout_q[0][3];
  assign w21_out = wout_q[1][0]; assign w22_out = wout_q[1][1];
  assign w23_out = wout_q[1][2]; assign w24_out = wout_q[1][3];
  assign w31_out = wout_q[2][0]; assign w32_out = wout_q[2][1];
  assign w33_out = wout_q[2][2]; assign w34_out = wout_q[2][3];
  assign w41_out = wout_q[3][0]; assign w42_out = wout_q[3][1];
  assign w43_out = wout_q[3][2]; assign w44_out = wout_q[3][3];

  for (genvar r = 0; r < 4; r++) begin : g_row
    fastica_row #(.ACC_W(ACC_W)) u_row (
      .clk    (clk_fast),
      .rst_n  (rstn_fast),
      .clr    (clr),
      .acc_en (v3_q),
      .w_row  (w_q[r]),
      .z_s0   (z_in),
      .z_s3   (z3_q),
      .acc    (acc_m[r])
    );
  end

  // Sequencing, W latch, z delay line and final W+ computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    w_d     = w_q;
    wout_d  = wout_q;
    clr     = 1'b0;
    mean    = '0;
    w3      = '0;
    diff    = '0;
    // Sample valid tracks the z delay line so accumulation lines up with g.
    v1_d    = (state_q == ST_RUN);
    v2_d    = v1_q;
    v3_d    = v2_q;
    z1_d    = z_in;
    z2_d    = z1_q;
    z3_d    = z2_q;
    case (state_q)
      ST_IDLE: begin
        if (go_fast) begin
          w_d     = w_in_m;
          clr     = 1'b1;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RUN_LAST) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        for (int unsigned i = 0; i < 4; i++) begin
          for (int unsigned j = 0; j < 4; j++) begin
            mean         = sat(64'(acc_m[i][j] >>> LOG2_NSAMP));
            w3           = w3_t'(w_q[i][j]) + (w3_t'(w_q[i][j]) <<< 1);
            diff         = diff_t'(mean) - diff_t'(w3);
            wout_d[i][j] = sat(64'(diff));
          end
        end
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk_fast or negedge rstn_fast) begin
    if (!rstn_fast) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      w_q     <= '{default: '0};
      wout_q  <= '{default: '0};
      z1_q    <= '{default: '0};
      z2_q    <= '{default: '0};
      z3_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      w_q     <= w_d;
      wout_q  <= wout_d;
      z1_q    <= z1_d;
      z2_q    <= z2_d;
      z3_q    <= z3_d;
    end
  end

endmodule

// File: tb/tb_fastica_one_unit.sv
// Directed bench for fastica_one_unit with LOG2_NSAMP=2 (4 samples per update).
module tb_fastica_one_unit;

  typedef struct packed {
    logic [15:0][25:0] w;   // index i*4+j
    logic [15:0][25:0] z;   // index sample*4+channel
    logic [15:0][25:0] e;   // expected W+, index i*4+j
  } vec_t;

  logic               clk;
  logic               rstn;
  logic               go;
  logic signed [25:0] z [4];
  logic signed [25:0] w_in [4][4];
  logic signed [25:0] w_out [4][4];
  logic               busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  vec_t vecs [6];

  fastica_one_unit #(.LOG2_NSAMP(2), .ACC_W(56)) dut (
    .clk_fast (clk), .rstn_fast (rstn), .go_fast (go),
    .z1 (z[0]), .z2 (z[1]), .z3 (z[2]), .z4 (z[3]),
    .w11_in (w_in[0][0]), .w12_in (w_in[0][1]), .w13_in (w_in[0][2]), .w14_in (w_in[0][3]),
    .w21_in (w_in[1][0]), .w22_in (w_in[1][1]), .w23_in (w_in[1][2]), .w24_in (w_in[1][3]),
    .w31_in (w_in[2][0]), .w32_in (w_in[2][1]), .w33_in (w_in[2][2]), .w34_in (w_in[2][3]),
    .w41_in (w_in[3][0]), .w42_in (w_in[3][1]), .w43_in (w_in[3][2]), .w44_in (w_in[3][3]),
    .fast_busy (busy),
    .w11_out (w_out[0][0]), .w12_out (w_out[0][1]), .w13_out (w_out[0][2]), .w14_out (w_out[0][3]),
    .w21_out (w_out[1][0]), .w22_out (w_out[1][1]), .w23_out (w_out[1][2]), .w24_out (w_out[1][3]),
    .w31_out (w_out[2][0]), .w32_out (w_out[2][1]), .w33_out (w_out[2][2]), .w34_out (w_out[2][3]),
    .w41_out (w_out[3][0]), .w42_out (w_out[3][1]), .w43_out (w_out[3][2]), .w44_out (w_out[3][3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [25:0] sat26(input longint x);
    if (x > 33554431) return 26'(33554431);
    if (x < -33554432) return 26'(-33554432);
    return 26'(x);
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int outs_nonzero();
    int n = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (w_out[i][j] != 0) n++;
    return n;
  endfunction

  task automatic check_outs(input vec_t v, input string tag);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("%s_w%0d%0d", tag, i + 1, j + 1), w_out[i][j], $signed(v.e[i*4+j]));
  endtask

  // Start a run, feed four samples, count busy edges, then compare W+.
  task automatic run_vec(input vec_t v, input bit hold, input string tag);
    int n;
    bit done;
    @(negedge clk);
    go = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        w_in[i][j] = $signed(v.w[i*4+j]);
    for (int c = 0; c < 4; c++) z[c] = '0;
    @(posedge clk);
    #1;
    chk({tag, "_busy_start"}, 64'(busy), 1);
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      go = hold;
      for (int c = 0; c < 4; c++) z[c] = (n < 4) ? $signed(v.z[n*4+c]) : 26'sd0;
      @(posedge clk);
      n++;
      #1;
      if (!busy) done = 1'b1;
    end
    chk({tag, "_busy_edges"}, 64'(n), 8);
    check_outs(v, tag);
  endtask

  initial begin
    logic signed [25:0] snap [4][4];
    int wv;

    // Vector 0: identity W, constant z=1.0.
    for (int k = 0; k < 16; k++) begin
      vecs[0].w[k] = (k % 5 == 0) ? 26'(8192) : 26'(0);
      vecs[0].z[k] = 26'(8192);
      vecs[0].e[k] = (k % 5 == 0) ? 26'(-16384) : 26'(8192);
    end
    // Vector 1: z=0, result is sat(-3W), including both rails.
    for (int k = 0; k < 16; k++) begin
      wv = (k % 2 == 0) ? (1000 + 111 * k) : -(1000 + 111 * k);
      if (k == 0) wv = 33554431;
      if (k == 1) wv = -33554432;
      if (k == 2) wv = 1000;
      vecs[1].w[k] = 26'(wv);
      vecs[1].z[k] = '0;
      vecs[1].e[k] = sat26(-3 * longint'(wv));
    end
    // Vector 2: W=0, ramp z.
    for (int k = 0; k < 16; k++) begin
      vecs[2].w[k] = '0;
      vecs[2].z[k] = 26'(8200 * (k / 4 + 1));
      vecs[2].e[k] = '0;
    end
    // Vector 3: identity W, z=2**24; cube saturates.
    for (int k = 0; k < 16; k++) begin
      vecs[3].w[k] = (k % 5 == 0) ? 26'(8192) : 26'(0);
      vecs[3].z[k] = 26'(1 << 24);
      vecs[3].e[k] = (k % 5 == 0) ? 26'(33529855) : 26'(33554431);
    end
    // Vector 4: fractional and negative row weights, floor shifts.
    for (int k = 0; k < 16; k++) begin
      vecs[4].w[k] = '0;
      vecs[4].z[k] = 26'(8192);
      vecs[4].e[k] = '0;
    end
    vecs[4].w[0] = 26'(4096);
    vecs[4].w[4] = 26'(-4096);
    vecs[4].w[8] = 26'(-1);
    vecs[4].e[0] = 26'(-11264);
    vecs[4].e[1] = 26'(1024); vecs[4].e[2] = 26'(1024); vecs[4].e[3] = 26'(1024);
    vecs[4].e[4] = 26'(11264);
    vecs[4].e[5] = 26'(-1024); vecs[4].e[6] = 26'(-1024); vecs[4].e[7] = 26'(-1024);
    vecs[4].e[8] = 26'(3);
    // Vector 5: identity W, per-channel z = {1.0, 2.0, -1.0, 0}.
    for (int k = 0; k < 16; k++) begin
      vecs[5].w[k] = (k % 5 == 0) ? 26'(8192) : 26'(0);
      case (k % 4)
        0: vecs[5].z[k] = 26'(8192);
        1: vecs[5].z[k] = 26'(16384);
        2: vecs[5].z[k] = 26'(-8192);
        default: vecs[5].z[k] = 26'(0);
      endcase
    end
    vecs[5].e[0]  = 26'(-16384); vecs[5].e[1]  = 26'(16384);  vecs[5].e[2]  = 26'(-8192);  vecs[5].e[3]  = 26'(0);
    vecs[5].e[4]  = 26'(65536);  vecs[5].e[5]  = 26'(106496); vecs[5].e[6]  = 26'(-65536); vecs[5].e[7]  = 26'(0);
    vecs[5].e[8]  = 26'(-8192);  vecs[5].e[9]  = 26'(-16384); vecs[5].e[10] = 26'(-16384); vecs[5].e[11] = 26'(0);
    vecs[5].e[12] = 26'(0);      vecs[5].e[13] = 26'(0);      vecs[5].e[14] = 26'(0);      vecs[5].e[15] = 26'(-24576);

    rstn = 1'b0;
    go   = 1'b0;
    for (int c = 0; c < 4; c++) z[c] = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        w_in[i][j] = '0;
    #12;
    chk("reset_busy", 64'(busy), 0);
    chk("reset_outs_nonzero", 64'(outs_nonzero()), 0);
    @(negedge clk);
    rstn = 1'b1;

    for (int t = 0; t < 6; t++) run_vec(vecs[t], 1'b0, $sformatf("vec%0d", t));

    // Outputs hold after completion even when wIJ_in changes.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        snap[i][j] = w_out[i][j];
        w_in[i][j] = 26'(1234 * (i + 1) - 777 * j);
      end
    repeat (5) @(posedge clk);
    #1;
    chk("hold_busy", 64'(busy), 0);
    chk("hold_w23", w_out[1][2], snap[1][2]);
    chk("hold_w44", w_out[3][3], snap[3][3]);

    // go held high: back-to-back runs, each re-latching wIJ_in.
    run_vec(vecs[0], 1'b1, "b2b_a");
    run_vec(vecs[4], 1'b1, "b2b_b");
    run_vec(vecs[0], 1'b0, "b2b_c");

    // Reset during RUN sample 2, then a fresh run.
    @(negedge clk);
    go = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        w_in[i][j] = $signed(vecs[3].w[i*4+j]);
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    for (int c = 0; c < 4; c++) z[c] = 26'(1 << 24);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("midrun_busy_pre", 64'(busy), 1);
    rstn = 1'b0;
    #1;
    chk("midrun_reset_busy", 64'(busy), 0);
    chk("midrun_reset_outs_nonzero", 64'(outs_nonzero()), 0);
    @(negedge clk);
    rstn = 1'b1;
    run_vec(vecs[0], 1'b0, "post_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
